// File: rtl/unpacker_8to12_if.sv
// Bundles the packed-byte input stream, the 12-bit sample output stream and the
// unpacker status signals. The slave modport is the unpacker side.
interface unpacker_8to12_if #(
  parameter int CNT_BITS = 32
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ack;
  logic                resync;
  logic [11:0]         out_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          phase;
  logic [CNT_BITS-1:0] sample_count;

  modport master (
    output in_data, in_valid, resync, out_ready,
    input  in_ack, out_data, out_valid, phase, sample_count
  );

  modport slave (
    input  in_data, in_valid, resync, out_ready,
    output in_ack, out_data, out_valid, phase, sample_count
  );
endinterface

// File: rtl/unpacker_8to12.sv
// Rebuilds pairs of 12-bit samples from a packed 3-byte stream:
// B0 = s0[7:0], B1 = {s1[3:0], s0[11:8]}, B2 = s1[11:4].
//
//  state | meaning
//  PH_B0 | expecting B0; byte is stored, no output slot needed
//  PH_B1 | expecting B1; completes s0, keeps upper nibble for s1
//  PH_B2 | expecting B2; completes s1
module unpacker_8to12 #(
  parameter int CNT_BITS = 32
) (
  input logic             clk,
  input logic             nreset,
  unpacker_8to12_if.slave bus
);

  typedef enum logic [1:0] {
    PH_B0 = 2'd0,
    PH_B1 = 2'd1,
    PH_B2 = 2'd2
  } phase_t;

  phase_t              r_phase, w_phase_nxt;
  logic [7:0]          r_lo, w_lo_nxt;
  logic [3:0]          r_hi_nib, w_hi_nib_nxt;
  logic [11:0]         r_out_data, w_out_data_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic [CNT_BITS-1:0] r_count;
  logic                w_slot_free;
  logic                w_ack;
  logic                w_complete;
  logic                w_handoff;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_ack       = bus.in_valid && !bus.resync && (r_phase == PH_B0 || w_slot_free);
  assign w_handoff   = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_phase     <= PH_B0;
      r_lo        <= '0;
      r_hi_nib    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_lo        <= w_lo_nxt;
      r_hi_nib    <= w_hi_nib_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_handoff) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_phase_nxt    = r_phase;
    w_lo_nxt       = r_lo;
    w_hi_nib_nxt   = r_hi_nib;
    w_out_data_nxt = r_out_data;
    w_complete     = 1'b0;

    // resync drops the partial pair but leaves the output slot untouched
    if (bus.resync) begin
      w_phase_nxt  = PH_B0;
      w_lo_nxt     = '0;
      w_hi_nib_nxt = '0;
    end else if (w_ack) begin
      case (r_phase)
        PH_B0: begin
          w_lo_nxt    = bus.in_data;
          w_phase_nxt = PH_B1;
        end
        PH_B1: begin
          w_out_data_nxt = {bus.in_data[3:0], r_lo};
          w_hi_nib_nxt   = bus.in_data[7:4];
          w_complete     = 1'b1;
          w_phase_nxt    = PH_B2;
        end
        PH_B2: begin
          w_out_data_nxt = {bus.in_data, r_hi_nib};
          w_complete     = 1'b1;
          w_phase_nxt    = PH_B0;
        end
        default: w_phase_nxt = PH_B0;
      endcase
    end

    if (w_complete)         w_out_valid_nxt = 1'b1;
    else if (bus.out_ready) w_out_valid_nxt = 1'b0;
    else                    w_out_valid_nxt = r_out_valid;
  end

  assign bus.in_ack       = w_ack;
  assign bus.out_data     = r_out_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.phase        = r_phase;
  assign bus.sample_count = r_count;

endmodule

// File: tb/tb_unpacker_8to12.sv
// Directed and loopback bench for unpacker_8to12; expected samples are queued
// by the stimulus and consumed by an independent output monitor.
module tb_unpacker_8to12;
  localparam int CNT = 4;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_count  = 0;
  logic rnd_ready = 1'b0;
  logic [11:0] exp_q[$];

  unpacker_8to12_if #(.CNT_BITS(CNT)) bus ();

  unpacker_8to12 #(.CNT_BITS(CNT)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Output monitor: pops one expected sample per handoff and tracks the counter.
  always @(negedge clk) begin
    if (!nreset) begin
      m_count = 0;
    end else begin
      check("sample_count", 32'(bus.sample_count), 32'(m_count % (1 << CNT)));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_sample: got 0x%0h with empty queue at %0t", bus.out_data, $time);
        end else begin
          check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        m_count++;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_byte(input logic [7:0] b, output int waited);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ack && waited <= 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited > 200) check("ack_timeout", 32'(waited), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 nreset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_phase", 32'(bus.phase), 32'd0);
    check("rst_count", 32'(bus.sample_count), 32'd0);
    @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    logic [11:0] s0, s1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.resync    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_out_valid", 32'(bus.out_valid), 32'd0);
    check("init_phase", 32'(bus.phase), 32'd0);
    nreset = 1'b1;

    // Reset mid-stream: partial pair held with sink stalled, then dropped.
    send_byte(8'h34, w);
    send_byte(8'h12, w);
    check("mid_valid_before_rst", 32'(bus.out_valid), 32'd1);
    pulse_reset();
    bus.out_ready = 1'b1;

    // Continuous streaming at full rate.
    exp_q.push_back(12'h234);
    exp_q.push_back(12'hAB1);
    send_byte(8'h34, w);
    check("t2_wait_b0", 32'(w), 32'd0);
    send_byte(8'h12, w);
    check("t2_wait_b1", 32'(w), 32'd0);
    check("t2_lat_s0", {bus.out_valid, 19'd0, bus.out_data}, {1'b1, 19'd0, 12'h234});
    send_byte(8'hAB, w);
    check("t2_wait_b2", 32'(w), 32'd0);
    check("t2_lat_s1", {bus.out_valid, 19'd0, bus.out_data}, {1'b1, 19'd0, 12'hAB1});
    drain();
    check("t2_count", 32'(bus.sample_count), 32'd2);

    // Backpressure on the completing byte.
    exp_q.push_back(12'h234);
    exp_q.push_back(12'hAB1);
    send_byte(8'h34, w);
    send_byte(8'h12, w);
    bus.out_ready = 1'b0;
    bus.in_data   = 8'hAB;
    bus.in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_ack_blocked", 32'(bus.in_ack), 32'd0);
      check("t3_hold", {bus.out_valid, 19'd0, bus.out_data}, {1'b1, 19'd0, 12'h234});
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_ack_release", 32'(bus.in_ack), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("t3_s1", {bus.out_valid, 19'd0, bus.out_data}, {1'b1, 19'd0, 12'hAB1});
    drain();

    // resync after a stray B0, with a byte offered during the resync cycle.
    send_byte(8'hFF, w);
    check("t5_phase_b1", 32'(bus.phase), 32'd1);
    bus.resync   = 1'b1;
    bus.in_data  = 8'h34;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("t5_ack_resync", 32'(bus.in_ack), 32'd0);
    @(posedge clk);
    #1 bus.resync = 1'b0;
    check("t5_phase_b0", 32'(bus.phase), 32'd0);
    exp_q.push_back(12'h234);
    exp_q.push_back(12'hAB1);
    send_byte(8'h34, w);
    send_byte(8'h12, w);
    send_byte(8'hAB, w);
    drain();

    // Loopback from a behavioural packer with a randomly stalling sink.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s0 = 12'($urandom);
      s1 = 12'($urandom);
      exp_q.push_back(s0);
      exp_q.push_back(s1);
      send_byte(s0[7:0], w);
      send_byte({s1[3:0], s0[11:8]}, w);
      send_byte(s1[11:4], w);
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain();

    // Counter wrap: 17 samples into a 4-bit counter.
    pulse_reset();
    bus.out_ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back(12'h100 + 12'(2 * p));
      exp_q.push_back(12'h100 + 12'(2 * p + 1));
      s0 = 12'h100 + 12'(2 * p);
      s1 = 12'h100 + 12'(2 * p + 1);
      send_byte(s0[7:0], w);
      send_byte({s1[3:0], s0[11:8]}, w);
      send_byte(s1[11:4], w);
    end
    exp_q.push_back(12'h5A7);
    send_byte(8'hA7, w);
    send_byte(8'h05, w);
    drain();
    check("t6_wrap", 32'(bus.sample_count), 32'd1);
    check("t6_phase", 32'(bus.phase), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end
endmodule
